alu_op_sequencer: RTL and testbench

- Upstream issue stage for the 4-bit ALU (ALU_model).
- Buffers instruction words in a small FIFO and drives registered opcode and operand pairs into the ALU. Operand 1 is either the immediate or a chained accumulator.
- Captures the ALU's combinational result one cycle after issue and presents it on a valid/ready result port.

---
 rtl/alu_op_sequencer_if.sv | 36 +++
 rtl/alu_op_sequencer.sv | 165 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Instruction and result handshake bundle for alu_op_sequencer.
// slave = sequencer side, master = producer/consumer side.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 4,
  parameter int OPC_W  = 3
);
  localparam int IW = OPC_W + 2*DATA_W + 1;

  logic              instr_valid;
  logic              instr_ready;
  logic [IW-1:0]     instr_data;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [OPC_W-1:0]  res_opcode;

  modport slave (
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    output res_valid,
    input  res_ready,
    output res_data,
    output res_opcode
  );

  modport master (
    output instr_valid,
    input  instr_ready,
    output instr_data,
    input  res_valid,
    output res_ready,
    input  res_data,
    input  res_opcode
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 4-bit ALU: instruction FIFO, operand/accumulator
// chaining, result capture. Optional op_count via ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
  parameter int DATA_W     = 4,
  parameter int OPC_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  alu_op_sequencer_if.slave               bus,
  output logic [OPC_W-1:0]                alu_opcode,
  output logic [DATA_W-1:0]               alu_operand_1,
  output logic [DATA_W-1:0]               alu_operand_2,
  input  logic [DATA_W-1:0]               alu_result,
  output logic [DATA_W-1:0]               acc_out,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
`ifdef ALU_SEQ_STATS_EN
  output logic [7:0]                      op_count,
`endif
  output logic                            busy
);

  localparam int IW = OPC_W + 2*DATA_W + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_HOLD
  } state_t;

  state_t              state;
  logic [IW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [DATA_W-1:0]   acc;
  logic                res_valid_q;
  logic [DATA_W-1:0]   res_data_q;
  logic [OPC_W-1:0]    res_opc_q;

  logic                push;
  logic                pop;
  logic                can_pop;
  logic [IW-1:0]       head;
  logic                h_use;
  logic [OPC_W-1:0]    h_opc;
  logic [DATA_W-1:0]   h_op1;
  logic [DATA_W-1:0]   h_op2;
  logic [DATA_W-1:0]   ld_op1;

  assign bus.instr_ready = (count < CW'(FIFO_DEPTH));
  assign push = bus.instr_valid && bus.instr_ready;

  assign can_pop = (count != '0);
  assign pop = can_pop &&
               ((state == S_IDLE) ||
                ((state == S_HOLD) && bus.res_ready));

  assign head  = mem[rd_ptr];
  assign h_op2 = head[DATA_W-1:0];
  assign h_op1 = head[2*DATA_W-1:DATA_W];
  assign h_opc = head[2*DATA_W+OPC_W-1:2*DATA_W];
  assign h_use = head[IW-1];

  // accumulator is already current here, so chaining needs no bypass
  assign ld_op1 = h_use ? acc : h_op1;

  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_opcode = res_opc_q;
  assign acc_out        = acc;
  assign fifo_count     = count;
  assign busy = (state != S_IDLE) || (count != '0);

  // FIFO storage; contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.instr_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case (1'b1)
        (push && !pop): count <= count + CW'(1);
        (pop && !push): count <= count - CW'(1);
        default:        count <= count;
      endcase
    end
  end

  // issue/capture FSM with registered ALU and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      alu_opcode    <= '0;
      alu_operand_1 <= '0;
      alu_operand_2 <= '0;
      acc           <= '0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_opc_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            alu_opcode    <= h_opc;
            alu_operand_1 <= ld_op1;
            alu_operand_2 <= h_op2;
            state         <= S_EXEC;
          end
        end
        S_EXEC: begin
          acc         <= alu_result;
          res_data_q  <= alu_result;
          res_opc_q   <= alu_opcode;
          res_valid_q <= 1'b1;
          state       <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              alu_opcode    <= h_opc;
              alu_operand_1 <= ld_op1;
              alu_operand_2 <= h_op2;
              state         <= S_EXEC;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // saturating count of accepted results
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (bus.res_valid && bus.res_ready &&
                 (op_count != 8'hFF)) begin
      op_count <= op_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed steps plus random traffic
// against a push-order result model with an add-mod-16 ALU stub.
module tb_alu_op_sequencer;

  localparam int DW    = 4;
  localparam int OW    = 3;
  localparam int DEPTH = 4;
  localparam int IW    = OW + 2*DW + 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DW-1:0] d;
    logic [OW-1:0] o;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(DW), .OPC_W(OW)) bus();

  logic [OW-1:0] alu_opcode;
  logic [DW-1:0] alu_operand_1;
  logic [DW-1:0] alu_operand_2;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] acc_out;
  logic [CW-1:0] fifo_count;
  logic          busy;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0]    op_count;
`endif

  assign alu_result = alu_operand_1 + alu_operand_2;

  alu_op_sequencer #(
    .DATA_W(DW), .OPC_W(OW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .alu_opcode(alu_opcode),
    .alu_operand_1(alu_operand_1),
    .alu_operand_2(alu_operand_2),
    .alu_result(alu_result),
    .acc_out(acc_out),
    .fifo_count(fifo_count),
`ifdef ALU_SEQ_STATS_EN
    .op_count(op_count),
`endif
    .busy(busy)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;
  int   n_done = 0;
  int   m_acc = 0;
  exp_t q[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic u,
                                       input logic [OW-1:0] o,
                                       input logic [DW-1:0] a,
                                       input logic [DW-1:0] b);
    return {u, o, a, b};
  endfunction

  // Model: results come out in push order; each result is
  // (use_acc ? previous result : op1) + op2, mod 16.
  task automatic sb_check();
    logic [IW-1:0] w;
    exp_t e;
    int r;
    if (reset) begin
      q.delete();
      m_acc = 0;
    end else begin
      if (bus.res_valid && bus.res_ready) begin
        if (q.size() == 0) begin
          check("spurious_result", 32'(bus.res_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check("res_data", 32'(bus.res_data), 32'(e.d));
          check("res_opcode", 32'(bus.res_opcode), 32'(e.o));
          n_done++;
        end
      end
      if (bus.instr_valid && bus.instr_ready) begin
        w = bus.instr_data;
        r = w[IW-1] ? m_acc : int'(w[2*DW-1:DW]);
        r = (r + int'(w[DW-1:0])) % 16;
        m_acc = r;
        e.d = DW'(r);
        e.o = w[2*DW+OW-1:2*DW];
        q.push_back(e);
        n_push++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int target,
                           input int budget);
    for (int k = 0; k < budget && n_done < target; k++) step();
    check(tag, 32'(n_done), 32'(target));
  endtask

  initial begin
    int base;
    int guard;
    int target;
    bus.instr_valid = 1'b0;
    bus.instr_data  = '0;
    bus.res_ready   = 1'b0;

    // reset state
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_acc", 32'(acc_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_alu_opc", 32'(alu_opcode), 32'd0);
    check("rst_alu_op1", 32'(alu_operand_1), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);

    // single issue latency
    bus.res_ready   = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(1'b0, 3'd0, 4'd3, 4'd1);
    step();
    bus.instr_valid = 1'b0;
    check("si_count", 32'(fifo_count), 32'd1);
    check("si_busy", 32'(busy), 32'd1);
    step();
    check("si_alu_opc", 32'(alu_opcode), 32'd0);
    check("si_alu_op1", 32'(alu_operand_1), 32'd3);
    check("si_alu_op2", 32'(alu_operand_2), 32'd1);
    check("si_not_yet", 32'(bus.res_valid), 32'd0);
    step();
    check("si_valid", 32'(bus.res_valid), 32'd1);
    check("si_data", 32'(bus.res_data), 32'd4);
    check("si_opc", 32'(bus.res_opcode), 32'd0);
    step();
    check("si_valid_clr", 32'(bus.res_valid), 32'd0);
    check("si_idle", 32'(busy), 32'd0);

    // accumulator chaining
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(1'b0, 3'd0, 4'd3, 4'd1);
    step();
    bus.instr_data  = mk(1'b1, 3'd1, 4'd9, 4'd2);
    step();
    bus.instr_valid = 1'b0;
    step();
    step();
    check("ch_alu_op1", 32'(alu_operand_1), 32'd4);
    check("ch_alu_opc", 32'(alu_opcode), 32'd1);
    step();
    check("ch_valid", 32'(bus.res_valid), 32'd1);
    check("ch_data", 32'(bus.res_data), 32'd6);
    step();
    check("ch_acc", 32'(acc_out), 32'd6);

    // backpressure and full FIFO
    bus.res_ready = 1'b0;
    base = n_push;
    for (int i = 0; i < 6; i++) begin
      bus.instr_valid = 1'b1;
      bus.instr_data  = mk(1'($urandom), 3'($urandom),
                           4'($urandom), 4'($urandom));
      step();
    end
    bus.instr_valid = 1'b0;
    check("bp_accepted", 32'(n_push - base), 32'd5);
    check("bp_full_count", 32'(fifo_count), 32'd4);
    check("bp_not_ready", 32'(bus.instr_ready), 32'd0);
    check("bp_valid", 32'(bus.res_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_data", 32'(bus.res_data), 32'(q[0].d));
    end
    bus.res_ready = 1'b1;
    wait_done("bp_drain", n_done + q.size(), 40);
    check("bp_empty", 32'(fifo_count), 32'd0);

    // wrap-around: operands i,1 then 15,1
    base = n_push;
    guard = 0;
    while (n_push < base + 10 && guard < 100) begin
      bus.instr_valid = 1'b1;
      bus.instr_data  = mk(1'b0, 3'($urandom),
                           DW'(n_push - base), 4'd1);
      step();
      guard++;
    end
    bus.instr_data = mk(1'b0, 3'd5, 4'd15, 4'd1);
    guard = 0;
    while (n_push < base + 11 && guard < 20) begin
      step();
      guard++;
    end
    bus.instr_valid = 1'b0;
    check("wr_pushed", 32'(n_push - base), 32'd11);
    wait_done("wr_drain", n_done + q.size(), 60);
    check("wr_acc_wrap", 32'(acc_out), 32'd0);
    check("wr_busy", 32'(busy), 32'd0);

    // reset while holding with three buffered
    bus.res_ready = 1'b0;
    base = n_push;
    guard = 0;
    while (n_push < base + 4 && guard < 20) begin
      bus.instr_valid = 1'b1;
      bus.instr_data  = mk(1'b0, 3'($urandom),
                           4'($urandom), 4'($urandom));
      step();
      guard++;
    end
    bus.instr_valid = 1'b0;
    check("rm_valid", 32'(bus.res_valid), 32'd1);
    check("rm_count", 32'(fifo_count), 32'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rm_res_valid", 32'(bus.res_valid), 32'd0);
    check("rm_count0", 32'(fifo_count), 32'd0);
    check("rm_acc", 32'(acc_out), 32'd0);
    check("rm_ready", 32'(bus.instr_ready), 32'd1);
    check("rm_busy", 32'(busy), 32'd0);
    bus.res_ready = 1'b1;
    target = n_done;
    repeat (10) step();
    check("rm_no_stale", 32'(n_done), 32'(target));

    // random traffic
    for (int i = 0; i < 80; i++) begin
      bus.instr_valid = 1'($urandom_range(0, 1));
      bus.instr_data  = mk(1'($urandom), 3'($urandom),
                           4'($urandom), 4'($urandom));
      bus.res_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.instr_valid = 1'b0;
    bus.res_ready   = 1'b1;
    wait_done("rnd_drain", n_done + q.size(), 60);

`ifdef ALU_SEQ_STATS_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("st_reset", 32'(op_count), 32'd0);
    base = n_push;
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(1'b0, 3'd2, 4'd1, 4'd1);
    guard = 0;
    while (n_push < base + 4 && guard < 40) begin
      step();
      guard++;
    end
    bus.instr_valid = 1'b0;
    wait_done("st_three", n_done + 3, 30);
    bus.res_ready = 1'b0;
    repeat (6) step();
    check("st_stalled", 32'(bus.res_valid), 32'd1);
    check("st_op3", 32'(op_count), 32'd3);
    bus.res_ready = 1'b1;
    base = n_push;
    bus.instr_valid = 1'b1;
    guard = 0;
    while (n_push < base + 300 && guard < 2000) begin
      step();
      guard++;
    end
    bus.instr_valid = 1'b0;
    wait_done("st_drain", n_done + q.size(), 40);
    check("st_sat", 32'(op_count), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
